// File: rtl/rx_serial_7e1.sv
// ---------------------------------------------------------------------------
// rx_serial_7e1
//   Asynchronous serial receiver for 7E1 frames:
//     idle 1, start 0, 7 data bits LSB first, parity bit, stop 1.
//   The serial line is brought into the clock domain through a 2-flop
//   synchronizer. A single FSM with a bit-timing counter samples every bit
//   at its centre, then publishes the character and its status flags.
//
// Optional build feature (macro RX_MAJORITY_EN):
//   When defined, every bit decision is the 2-of-3 majority of rx at ticks
//   c-1, c and c+1 around the nominal centre c, and the decision itself is
//   taken at c+1. Only the start check is stretched by that extra cycle;
//   later bits keep a CLKS_PER_BIT period, so their windows remain centred
//   on the true bit centres and pronto arrives one cycle later overall.
//   When undefined, a single sample is taken at tick c.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 8)
//   CW            width of the bit-timing counter
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous, active-high reset
//   dado_serial    in   serial line, asynchronous to clock
//   sel_paridade   in   0 = even parity, 1 = odd (looked at in FINAL only)
//   limpa          in   clears tem_dado
//   dados_ascii    out  [6:0] last received character
//   pronto         out  one-cycle pulse when a frame completes, good or bad
//   tem_dado       out  set on frame completion, held until limpa
//   erro_paridade  out  parity mismatch on the last frame
//   erro_frame     out  stop bit sampled 0 on the last frame
//   db_estado      out  [3:0] FSM state code for debug displays
//
// Delivery handshake: pronto is a single-cycle strobe with no back-pressure;
// the character and flags are valid from the pronto cycle until the next
// frame completes. tem_dado is a sticky "unread" flag: it is set by frame
// completion and cleared by limpa, and completion wins when both happen in
// the same cycle. A new frame overwrites the character regardless of
// tem_dado.
// ---------------------------------------------------------------------------
module rx_serial_7e1 #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  input  logic       sel_paridade,
  input  logic       limpa,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_paridade,
  output logic       erro_frame,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    INICIAL        = 3'd0,
    START          = 3'd1,
    DADOS          = 3'd2,
    PARIDADE       = 3'd3,
    STOP           = 3'd4,
    FINAL          = 3'd5,
    ESPERA_REPOUSO = 3'd6
  } state_t;

  // Decision ticks. Each state is entered with tick = 0, so a bit state
  // decides at CLKS_PER_BIT-1 and the next bit centre is exactly one bit
  // period later.
  localparam logic [CW-1:0] TICK_BIT   = CW'(CLKS_PER_BIT - 1);
`ifdef RX_MAJORITY_EN
  localparam logic [CW-1:0] TICK_START = CW'(CLKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0] TICK_START = CW'(CLKS_PER_BIT / 2 - 1);
`endif

  // Registered state
  state_t        state_q,     state_d;
  logic [CW-1:0] tick_q,      tick_d;
  logic [2:0]    bidx_q,      bidx_d;
  logic [6:0]    shift_q,     shift_d;
  logic          par_q,       par_d;
  logic          stop_q,      stop_d;
  logic [6:0]    data_q,      data_d;
  logic          pronto_q,    pronto_d;
  logic          tem_dado_q,  tem_dado_d;
  logic          erro_par_q,  erro_par_d;
  logic          erro_frm_q,  erro_frm_d;
  logic          sync1_q,     sync1_d;
  logic          sync2_q,     sync2_d;
`ifdef RX_MAJORITY_EN
  logic [1:0]    hist_q,      hist_d;
`endif

  logic rx;
  logic samp;

  assign rx = sync2_q;

  // Bit value used at a decision tick.
`ifdef RX_MAJORITY_EN
  // hist_q[1] = rx at c-1, hist_q[0] = rx at c, rx = rx at c+1.
  assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);
`else
  assign samp = rx;
`endif

  always_comb begin
    state_d    = state_q;
    tick_d     = '0;
    bidx_d     = bidx_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_d     = stop_q;
    data_d     = data_q;
    pronto_d   = 1'b0;
    tem_dado_d = tem_dado_q;
    erro_par_d = erro_par_q;
    erro_frm_d = erro_frm_q;
    sync1_d    = dado_serial;
    sync2_d    = sync1_q;
`ifdef RX_MAJORITY_EN
    hist_d     = {hist_q[0], rx};
`endif

    // Completion in FINAL below overrides this clear.
    if (limpa) begin
      tem_dado_d = 1'b0;
    end

    case (state_q)
      INICIAL: begin
        if (!rx) begin
          state_d = START;
        end
      end

      START: begin
        tick_d = tick_q + CW'(1);
        if (tick_q == TICK_START) begin
          tick_d = '0;
          bidx_d = 3'd0;
          // A line back at 1 by mid start bit was a glitch.
          state_d = samp ? INICIAL : DADOS;
        end
      end

      DADOS: begin
        tick_d = tick_q + CW'(1);
        if (tick_q == TICK_BIT) begin
          tick_d = '0;
          // Shifting in from the top leaves the first (LSB) bit in bit 0
          // after seven samples, i.e. sample bidx lands in bit bidx.
          shift_d = {samp, shift_q[6:1]};
          if (bidx_q == 3'd6) begin
            state_d = PARIDADE;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end
      end

      PARIDADE: begin
        tick_d = tick_q + CW'(1);
        if (tick_q == TICK_BIT) begin
          tick_d  = '0;
          par_d   = samp;
          state_d = STOP;
        end
      end

      STOP: begin
        tick_d = tick_q + CW'(1);
        if (tick_q == TICK_BIT) begin
          tick_d  = '0;
          stop_d  = samp;
          state_d = FINAL;
        end
      end

      FINAL: begin
        data_d     = shift_q;
        erro_par_d = ((^shift_q) ^ par_q) != sel_paridade;
        erro_frm_d = ~stop_q;
        pronto_d   = 1'b1;
        tem_dado_d = 1'b1;
        // A low stop bit may be a break; wait for idle before re-arming.
        state_d    = stop_q ? INICIAL : ESPERA_REPOUSO;
      end

      ESPERA_REPOUSO: begin
        if (rx) begin
          state_d = INICIAL;
        end
      end

      default: begin
        state_d = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= INICIAL;
      tick_q     <= '0;
      bidx_q     <= 3'd0;
      shift_q    <= 7'd0;
      par_q      <= 1'b0;
      stop_q     <= 1'b0;
      data_q     <= 7'd0;
      pronto_q   <= 1'b0;
      tem_dado_q <= 1'b0;
      erro_par_q <= 1'b0;
      erro_frm_q <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
`ifdef RX_MAJORITY_EN
      hist_q     <= 2'b11;
`endif
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bidx_q     <= bidx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      data_q     <= data_d;
      pronto_q   <= pronto_d;
      tem_dado_q <= tem_dado_d;
      erro_par_q <= erro_par_d;
      erro_frm_q <= erro_frm_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
`ifdef RX_MAJORITY_EN
      hist_q     <= hist_d;
`endif
    end
  end

  assign dados_ascii   = data_q;
  assign pronto        = pronto_q;
  assign tem_dado      = tem_dado_q;
  assign erro_paridade = erro_par_q;
  assign erro_frame    = erro_frm_q;
  assign db_estado     = {1'b0, state_q};

endmodule

// File: tb/tb_rx_serial_7e1.sv
// ---------------------------------------------------------------------------
// tb_rx_serial_7e1
//   Directed bench for rx_serial_7e1 with CLKS_PER_BIT = 16. The driver
//   pushes each frame's expected result (character, flags, falling-edge
//   cycle) into exp_q; a monitor pops and compares on every pronto.
// ---------------------------------------------------------------------------
module tb_rx_serial_7e1;

  localparam int CLKS = 16;
  localparam int W    = 41;  // {fall_cyc[31:0], erro_frame, erro_paridade, data[6:0]}

  logic       clock;
  logic       reset;
  logic       dado_serial;
  logic       sel_paridade;
  logic       limpa;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro_paridade;
  logic       erro_frame;
  logic [3:0] db_estado;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int           n_cmp;
  int           n_bad;
  int           cyc;
  logic         pronto_prev;
  logic         found_final;

  rx_serial_7e1 #(.CLKS_PER_BIT(CLKS)) dut (
    .clock        (clock),
    .reset        (reset),
    .dado_serial  (dado_serial),
    .sel_paridade (sel_paridade),
    .limpa        (limpa),
    .dados_ascii  (dados_ascii),
    .pronto       (pronto),
    .tem_dado     (tem_dado),
    .erro_paridade(erro_paridade),
    .erro_frame   (erro_frame),
    .db_estado    (db_estado)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drive tasks start and end just after a rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    dado_serial = b;
    repeat (CLKS) step();
  endtask

  task automatic idle(input int n);
    dado_serial = 1'b1;
    repeat (n) step();
  endtask

  // The falling edge is first sampled on the next rising edge (cyc + 1).
  task automatic send_frame(input logic [6:0] d, input logic p, input logic s,
                            input logic exp_ep, input logic exp_ef);
    logic [W-1:0] e;
    e = {32'(cyc + 1), exp_ef, exp_ep, d};
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic pulse_limpa();
    limpa = 1'b1;
    step();
    limpa = 1'b0;
    @(negedge clock);
    check("tem_dado_after_limpa", 32'(tem_dado), 32'd0);
    step();
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial pronto_prev = 1'b0;
  always @(negedge clock) begin
    if (pronto_prev) begin
      check("pronto_width", 32'(pronto), 32'd0);
    end
    if (pronto) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pronto: got pronto=1 with char 0x%0h expected no pronto (cycle %0d)",
                 dados_ascii, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("dados_ascii",   32'(dados_ascii),   32'(mon_e[6:0]));
        check("erro_paridade", 32'(erro_paridade), 32'(mon_e[7]));
        check("erro_frame",    32'(erro_frame),    32'(mon_e[8]));
        check("tem_dado_set",  32'(tem_dado),      32'd1);
        check("pronto_latency", 32'(cyc) - mon_e[40:9], 32'd155);
      end
    end
    pronto_prev = pronto;
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b1;
    dado_serial  = 1'b1;
    sel_paridade = 1'b0;
    limpa        = 1'b0;
    found_final  = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    check("rst_dados_ascii",   32'(dados_ascii),   32'd0);
    check("rst_pronto",        32'(pronto),        32'd0);
    check("rst_tem_dado",      32'(tem_dado),      32'd0);
    check("rst_erro_paridade", 32'(erro_paridade), 32'd0);
    check("rst_erro_frame",    32'(erro_frame),    32'd0);
    check("rst_db_estado",     32'(db_estado),     32'd0);
    step();
    idle(8);

    // 'A', correct even parity, good stop.
    send_frame(7'h41, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    @(negedge clock);
    check("a_tem_dado_held", 32'(tem_dado),    32'd1);
    check("a_dados_held",    32'(dados_ascii), 32'h41);
    step();
    pulse_limpa();

    // 'A' with wrong parity for even mode.
    send_frame(7'h41, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);

    // 'A' with p = 1 is correct in odd mode.
    sel_paridade = 1'b1;
    send_frame(7'h41, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(10);
    sel_paridade = 1'b0;

    // 0x55 with stop = 0, then the line held low for 40 more cycles.
    send_frame(7'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) step();
    @(negedge clock);
    check("break_db_estado", 32'(db_estado), 32'd6);
    repeat (20) step();
    idle(30);
    @(negedge clock);
    check("break_recovered_db", 32'(db_estado), 32'd0);
    step();

    // 4-cycle glitch: START is entered, then abandoned at mid start bit.
    dado_serial = 1'b0;
    repeat (4) step();
    dado_serial = 1'b1;
    @(negedge clock);
    check("glitch_in_start", 32'(db_estado), 32'd1);
    repeat (20) step();
    @(negedge clock);
    check("glitch_db_estado",  32'(db_estado),   32'd0);
    check("glitch_dados_kept", 32'(dados_ascii), 32'h55);
    check("glitch_frame_kept", 32'(erro_frame),  32'd1);
    step();
    idle(10);

    // Back-to-back 0x30 then 0x7F, no idle gap.
    send_frame(7'h30, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(7'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(10);

    // Partial frame interrupted by reset while in DADOS.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    @(negedge clock);
    check("pre_reset_in_dados", 32'(db_estado), 32'd2);
    step();
    reset       = 1'b1;
    dado_serial = 1'b1;
    step();
    @(negedge clock);
    check("mid_rst_dados_ascii",   32'(dados_ascii),   32'd0);
    check("mid_rst_tem_dado",      32'(tem_dado),      32'd0);
    check("mid_rst_erro_paridade", 32'(erro_paridade), 32'd0);
    check("mid_rst_erro_frame",    32'(erro_frame),    32'd0);
    check("mid_rst_db_estado",     32'(db_estado),     32'd0);
    reset = 1'b0;
    step();
    idle(20);
    send_frame(7'h41, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(10);
    pulse_limpa();

    // limpa asserted exactly in the FINAL cycle: set wins.
    fork
      send_frame(7'h2A, 1'b1, 1'b1, 1'b0, 1'b0);
      begin : limpa_in_final
        for (int i = 0; i < 400; i++) begin
          @(negedge clock);
          if (db_estado == 4'd5) begin
            found_final = 1'b1;
            break;
          end
        end
        check("final_state_seen", 32'(found_final), 32'd1);
        if (found_final) begin
          limpa = 1'b1;
          @(posedge clock);
          #1;
          limpa = 1'b0;
        end
      end
    join
    idle(5);
    @(negedge clock);
    check("limpa_final_tem_dado", 32'(tem_dado), 32'd1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clock);
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
